// File: rtl/fp_div_prep.sv
// FP32 divide front end: unpack, resolve specials, normalise subnormals into .1xxx fractions.
// Latency 2 edges to ready sampling (+1 per subnormal shift); start is ignored while busy, no stall input.
module fp_div_prep #(
  parameter int BIAS = 127,
  parameter int EXPW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     a,
  input  logic [31:0]     b,
  output logic            busy,
  output logic            ready,
  output logic [31:0]     frac_a,
  output logic [31:0]     frac_b,
  output logic [EXPW-1:0] exp_q,
  output logic            sign_q,
  output logic            special,
  output logic [31:0]     special_res
);

  typedef enum logic [1:0] {IDLE, CLASSIFY, NORM_A, NORM_B} state_t;

  localparam logic [EXPW-1:0] X_ONE  = EXPW'(1);
  localparam logic [EXPW-1:0] X_BIAS = EXPW'(BIAS);
  localparam logic [31:0]     QNAN   = 32'h7FC0_0000;

  state_t          state, state_nxt;
  logic [31:0]     a_r, b_r;
  logic [23:0]     sig_a, sig_b;
  logic [EXPW-1:0] xp_a, xp_b;

  // operand decode from the latched copies
  logic [7:0]      ea, eb;
  logic [22:0]     ma, mb;
  logic            a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
  logic [23:0]     sa_cls, sb_cls;
  logic [EXPW-1:0] xa_cls, xb_cls;

  assign ea     = a_r[30:23];
  assign eb     = b_r[30:23];
  assign ma     = a_r[22:0];
  assign mb     = b_r[22:0];
  assign sgn    = a_r[31] ^ b_r[31];
  assign a_nan  = (ea == 8'hFF) && (ma != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (mb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (ma == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (mb == 23'd0);
  assign a_zero = (ea == 8'h00) && (ma == 23'd0);
  assign b_zero = (eb == 8'h00) && (mb == 23'd0);
  assign sa_cls = {ea != 8'h00, ma};
  assign sb_cls = {eb != 8'h00, mb};
  assign xa_cls = (ea == 8'h00) ? X_ONE : {{(EXPW-8){1'b0}}, ea};
  assign xb_cls = (eb == 8'h00) ? X_ONE : {{(EXPW-8){1'b0}}, eb};

  logic            spec_any;
  logic [31:0]     spec_val;

  always_comb begin
    spec_any = 1'b1;
    spec_val = 32'd0;
    if (a_nan || b_nan)
      spec_val = QNAN;
    else if ((a_inf && b_inf) || (a_zero && b_zero))
      spec_val = QNAN;
    else if (a_inf || b_zero)
      spec_val = {sgn, 31'h7F80_0000};
    else if (a_zero || b_inf)
      spec_val = {sgn, 31'd0};
    else
      spec_any = 1'b0;
  end

  // next-state plus the candidate significand/exponent values for this cycle
  logic            load, done, spec_hit;
  logic [23:0]     sa_n, sb_n;
  logic [EXPW-1:0] xa_n, xb_n, exp_fin;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    done      = 1'b0;
    spec_hit  = 1'b0;
    sa_n      = sig_a;
    sb_n      = sig_b;
    xa_n      = xp_a;
    xb_n      = xp_b;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CLASSIFY;
        end
      end
      CLASSIFY: begin
        sa_n = sa_cls;
        sb_n = sb_cls;
        xa_n = xa_cls;
        xb_n = xb_cls;
        if (spec_any) begin
          spec_hit  = 1'b1;
          state_nxt = IDLE;
        end else if (!sa_cls[23]) begin
          state_nxt = NORM_A;
        end else if (!sb_cls[23]) begin
          state_nxt = NORM_B;
        end else begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      NORM_A: begin
        sa_n = sig_a << 1;
        xa_n = xp_a - X_ONE;
        if (sa_n[23]) begin
          if (!sig_b[23]) begin
            state_nxt = NORM_B;
          end else begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      NORM_B: begin
        sb_n = sig_b << 1;
        xb_n = xp_b - X_ONE;
        if (sb_n[23]) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    exp_fin = xa_n - xb_n + X_BIAS;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      sig_a       <= 24'd0;
      sig_b       <= 24'd0;
      xp_a        <= '0;
      xp_b        <= '0;
      busy        <= 1'b0;
      ready       <= 1'b0;
      frac_a      <= 32'd0;
      frac_b      <= 32'd0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      special     <= 1'b0;
      special_res <= 32'd0;
    end else begin
      ready <= 1'b0;
      sig_a <= sa_n;
      sig_b <= sb_n;
      xp_a  <= xa_n;
      xp_b  <= xb_n;
      if (load) begin
        a_r  <= a;
        b_r  <= b;
        busy <= 1'b1;
      end
      if (spec_hit) begin
        special     <= 1'b1;
        special_res <= spec_val;
        sign_q      <= sgn;
        busy        <= 1'b0;
        ready       <= 1'b1;
      end
      if (done) begin
        frac_a      <= {sa_n, 8'd0};
        frac_b      <= {sb_n, 8'd0};
        exp_q       <= exp_fin;
        sign_q      <= sgn;
        special     <= 1'b0;
        special_res <= 32'd0;
        busy        <= 1'b0;
        ready       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_prep.sv
// Random and directed operands for fp_div_prep, checked by a queued reference model.
module tb_fp_div_prep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy, ready, sign_q, special;
  logic [31:0] frac_a, frac_b, special_res;
  logic [9:0]  exp_q;

  fp_div_prep #(.BIAS(127), .EXPW(10)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .ready(ready), .frac_a(frac_a), .frac_b(frac_b),
    .exp_q(exp_q), .sign_q(sign_q), .special(special), .special_res(special_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        spec;
    logic [31:0] res;
    logic [31:0] fa;
    logic [31:0] fb;
    logic [9:0]  eq;
    logic        sgn;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic prev_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // value = sig * 2^(ex-150); scale sig up to [2^23, 2^24) counting the shifts
  function automatic void unpack(input logic [31:0] v, output int sig, output int ex, output int n);
    sig = int'(v[22:0]);
    ex  = int'(v[30:23]);
    if (ex == 0) ex = 1;
    else         sig = sig + (1 << 23);
    n = 0;
    while (sig < (1 << 23)) begin
      sig = sig * 2;
      ex  = ex - 1;
      n++;
    end
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input int now);
    exp_t r;
    int   sx, ex, nx, sy, ey, ny;
    logic s;
    bit   xnan, ynan, xinf, yinf, xz, yz;
    s    = x[31] ^ y[31];
    xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xinf = (x[30:0] == 31'h7F80_0000);
    yinf = (y[30:0] == 31'h7F80_0000);
    xz   = (x[30:0] == 31'd0);
    yz   = (y[30:0] == 31'd0);
    r.sgn  = s;
    r.spec = 1'b1;
    r.fa   = 32'd0;
    r.fb   = 32'd0;
    r.eq   = 10'd0;
    r.cyc  = now + 2;
    if (xnan || ynan || (xinf && yinf) || (xz && yz)) r.res = 32'h7FC0_0000;
    else if (xinf || yz)                              r.res = s ? 32'hFF80_0000 : 32'h7F80_0000;
    else if (xz || yinf)                              r.res = s ? 32'h8000_0000 : 32'h0000_0000;
    else begin
      unpack(x, sx, ex, nx);
      unpack(y, sy, ey, ny);
      r.spec = 1'b0;
      r.res  = 32'd0;
      r.fa   = 32'(sx) << 8;
      r.fb   = 32'(sy) << 8;
      r.eq   = 10'(ex - ey + 127);
      r.cyc  = now + 2 + nx + ny;
    end
    return r;
  endfunction

  // monitor: every ready pulse must match the oldest outstanding job
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (ready) begin
        check("ready_single_cycle", {31'd0, prev_ready}, 32'd0);
        if (sbq.size() == 0) begin
          check("spurious_ready", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          check("ready_cycle", cyc, e.cyc);
          check("special", {31'd0, special}, {31'd0, e.spec});
          check("special_res", special_res, e.res);
          check("sign_q", {31'd0, sign_q}, {31'd0, e.sgn});
          check("busy_at_ready", {31'd0, busy}, 32'd0);
          if (!e.spec) begin
            check("frac_a", frac_a, e.fa);
            check("frac_b", frac_b, e.fb);
            check("exp_q", {22'd0, exp_q}, {22'd0, e.eq});
          end
        end
      end
      prev_ready = ready;
    end
  end

  // called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("issue_wait_timeout", 32'd1, 32'd0);
    a = x;
    b = y;
    start = 1'b1;
    sbq.push_back(model(x, y, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_outstanding", sbq.size(), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready}, 32'd0);
    check({tag, "_special"}, {31'd0, special}, 32'd0);
    check({tag, "_sign_q"}, {31'd0, sign_q}, 32'd0);
    check({tag, "_frac_a"}, frac_a, 32'd0);
    check({tag, "_frac_b"}, frac_b, 32'd0);
    check({tag, "_exp_q"}, {22'd0, exp_q}, 32'd0);
    check({tag, "_special_res"}, special_res, 32'd0);
  endtask

  function automatic logic [31:0] rand_op();
    logic [22:0] m;
    logic [7:0]  e;
    logic        s;
    int          k;
    k = $urandom_range(0, 9);
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    e = 8'($urandom_range(1, 254));
    case (k)
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, m | 23'd1};
      3, 4: begin
        m = m >> $urandom_range(0, 22);
        if (m == 0) m = 23'd1;
        return {s, 8'h00, m};
      end
      default: return {s, e, m};
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    issue(32'h3F80_0000, 32'h4000_0000);
    drain();

    // smallest subnormal: busy must stay high for the whole normalisation
    issue(32'h0000_0001, 32'h3F80_0000);
    low = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) break;
      if (!busy) low++;
      @(negedge clk);
    end
    check("busy_throughout", low, 32'd0);
    drain();

    issue(32'h0040_0000, 32'h0020_0000);
    drain();
    issue(32'h7F80_0000, 32'hBF80_0000);
    drain();
    issue(32'h0000_0000, 32'h8000_0000);
    drain();
    issue(32'h3F80_0000, 32'h8000_0000);
    drain();

    // a second start while busy is ignored
    issue(32'h0000_0001, 32'h3F80_0000);
    repeat (3) @(negedge clk);
    a = 32'h4040_0000;
    b = 32'h7F80_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // reset mid-job discards it: zero outputs and no ready afterwards
    issue(32'h0000_0003, 32'h3F80_0000);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midreset");
    repeat (30) @(negedge clk);
    issue(32'h40A0_0000, 32'hC000_0000);
    drain();

    // back-to-back: the next start lands in the ready cycle of the previous job
    issue(32'h3F80_0000, 32'h4000_0000);
    issue(32'h4040_0000, 32'h3F00_0000);
    issue(32'h7FC0_1234, 32'h3F80_0000);
    drain();

    for (int i = 0; i < 200; i++) issue(rand_op(), rand_op());
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
